// File: rtl/mac_sequencer.sv
// Multiply-accumulate job sequencer driving an external shared 3x3 multiplier.
// Latency: 2 cycles per operand pair plus 1; a result appears in cycle 2N+1 after start.
// Backpressure: in_ready only in LOAD; the result is held in DONE until out_ready.
// Optional build macro MAC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mac_sequencer #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [2:0]       in_a,
    input  logic [2:0]       in_b,
    output logic             in_ready,
    output logic [2:0]       mul_a,
    output logic [2:0]       mul_b,
    input  logic [5:0]       mul_p,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;

    // One extra bit catches the carry out of the accumulator.
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;

    assign sum     = {1'b0, acc} + {{(ACC_W-5){1'b0}}, mul_p};
    assign carry   = sum[ACC_W];
    assign out_acc = acc;

    // Next accumulator value: wrap, or clamp once the job has overflowed.
    always_comb begin
        acc_nxt = sum[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
        if (ovf || carry) begin
            acc_nxt = '1;
        end
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    // Job FSM; handshake and busy flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        cnt  <= len;
                        if (len != '0) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            // Empty job: report a zero result straight away.
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    // mul_p reflects the operands captured in the previous LOAD.
                    acc <= acc_nxt;
                    ovf <= ovf | carry;
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; jobs begin only from IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator width in bits, minimum 6.
REQ-002 SHALL have parameter LEN_W, default 4: width of the pair-count field.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: job request, sampled in IDLE only.
REQ-006 SHALL have port len  input  LEN_W: number of operand pairs in the job, sampled with start.
REQ-007 SHALL have ports in_valid input 1, in_a input 3, in_b input 3, in_ready output 1: operand stream with valid/ready handshake.
REQ-008 SHALL have ports mul_a output 3, mul_b output 3, mul_p input 6: connection to the external shared 3x3 combinational multiplier.
REQ-009 SHALL have ports out_valid output 1, out_acc output ACC_W, ovf output 1, out_ready input 1: result handshake.
REQ-010 SHALL have port busy  output 1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD, MUL and DONE.
REQ-012 IDLE: start=1 with len>0 -> LOAD; clear acc and ovf; load counter with len.
REQ-013 IDLE: start=1 with len=0 -> DONE; acc=0, ovf=0.
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 LOAD: in_ready=1; on in_valid&in_ready, register in_a/in_b into mul_a/mul_b and go to MUL; without in_valid, stay in LOAD.
REQ-016 in_ready SHALL be 0 in IDLE, MUL and DONE.
REQ-017 MUL: acc <= acc + zero-extended mul_p; counter decrements; counter==1 -> DONE, else -> LOAD.
REQ-018 DONE: out_valid=1, out_acc=acc, ovf valid; these SHALL stay stable until out_ready=1, then go to IDLE.
REQ-019 mul_a/mul_b SHALL hold their last registered values outside LOAD-capture cycles.
REQ-020 Latency: start sampled at cycle 0, in_valid held high -> pair k accepted in cycle 2k-1, out_valid first high in cycle 2N+1.
REQ-021 ovf SHALL be set sticky for the job when an addition carries beyond ACC_W bits.
REQ-022 out_valid&out_ready in DONE with start=1 in the same cycle: start SHALL be ignored; a new job needs start in IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, acc=0, counter=0, mul_a=mul_b=0, ovf=0, out_valid=0, in_ready=0, busy=0.
REQ-024 Reset mid-job SHALL abandon the job with no result; after release the block idles until start.

Configuration
REQ-025 Macro MAC_SATURATE_EN defined: on overflow acc SHALL clamp to 2^ACC_W-1 and remain there for the job; ovf=1.
REQ-026 MAC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf=1.

Verification
REQ-027 len=3, pairs (1,1),(3,2),(7,7), in_valid always 1, out_ready=1 -> out_valid in cycle 7, out_acc=56, ovf=0.
REQ-028 len=0 with start -> out_valid in cycle 1, out_acc=0, in_ready never asserted.
REQ-029 ACC_W=8, len=6, all pairs (7,7) -> with MAC_SATURATE_EN out_acc=255, ovf=1; without it out_acc=38, ovf=1.
REQ-030 len=2, pairs (5,2),(6,1), in_valid low 3 cycles between pairs, out_ready low 4 cycles -> LOAD stalls, out_acc=16 held stable with out_valid until out_ready, then IDLE.
REQ-031 start pulsed during MUL of a len=2 job -> ignored; exactly one result is produced.
REQ-032 rst_n low for one cycle after the first pair of a len=3 job -> all outputs 0 immediately; a new len=1 job with pair (4,4) yields out_acc=16.
